// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiply-accumulate unit.
// Holds the FSM state encoding, counter sizing and operand magnitude function.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} mult_state_t;

  // Widest operand the magnitude helper handles.
  localparam int MAG_W = 32;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // |x| over the low w bits of x; raw bits when signed_mode is 0.
  // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] x, input int w,
                                           input logic signed_mode);
    logic [MAG_W-1:0] mask;
    logic             sbit;
    mask = (w >= MAG_W) ? '1 : ((MAG_W'(1) << w) - MAG_W'(1));
    sbit = x[5'(w - 1)];
    if (signed_mode && sbit) return (~x + MAG_W'(1)) & mask;
    return x & mask;
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiply-accumulate; start to done pulse is n+2 cycles (issue interval n+2).
// No queueing: start/clr_acc/operands are ignored while busy, so the controller must watch busy.
module mult_seq
  import mult_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic           acc_en,
  input  logic           clr_acc,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [2*n-1:0] result,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam int CW = cnt_width(n);
  localparam int W2 = 2 * n;
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  mult_state_t   state, state_nx;
  logic [CW-1:0] cnt;
  logic [W2-1:0] mcand;
  logic [W2-1:0] prod;
  logic [n-1:0]  mplier;
  logic          neg;
  logic          use_base;
  logic          sm_q;

  logic [W2-1:0] p;
  logic [W2-1:0] base;
  logic [W2:0]   sum;
  logic          add_ovf;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CNT_LAST) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result is stable through CALC, so the base is read at FINISH instead of being copied at start.
  always_comb begin
    p       = neg ? (~prod + W2'(1)) : prod;
    base    = use_base ? result : '0;
    sum     = {1'b0, base} + {1'b0, p};
    add_ovf = sm_q ? ((base[W2-1] == p[W2-1]) && (sum[W2-1] != base[W2-1])) : sum[W2];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      prod     <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      use_base <= 1'b0;
      sm_q     <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_acc) begin
            result <= '0;
            ovf    <= 1'b0;
          end
          if (start) begin
            mcand    <= W2'(mag(MAG_W'(a), n, signed_mode));
            mplier   <= n'(mag(MAG_W'(b), n, signed_mode));
            prod     <= '0;
            cnt      <= '0;
            neg      <= signed_mode & (a[n-1] ^ b[n-1]);
            use_base <= acc_en & ~clr_acc;
            sm_q     <= signed_mode;
          end
        end
        CALC: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
        FINISH: begin
          result <= sum[W2-1:0];
          done   <= 1'b1;
          if (add_ovf) ovf <= 1'b1;
          else if (!use_base) ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised multi-cycle multiply-accumulate unit for the NISC datapath. It is the successor to the single-cycle embedded multiplier. Adds over that unit:
- configurable operand width;
- per-operation signed/unsigned mode;
- accumulation into a held result register, with a sticky overflow flag;
- start/busy/done handshake, so the controller can issue a multiply and continue while it completes.

It uses a radix-2 shift-add datapath, trading latency for a small area.

## Interface
- `n`, 8, operand width in bits, n ≥ 2; result and accumulator width is 2n.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `nReset`  in  1  synchronous, active-low reset.
- `start`  in  1  request an operation; sampled only in IDLE.
- `signed_mode`  in  1  1 = a, b, and accumulation are two's complement; 0 = unsigned. Sampled with start.
- `acc_en`  in  1  1 = add the product to the current result; 0 = result becomes the product. Sampled with start.
- `clr_acc`  in  1  1 = clear result and overflow; sampled only in IDLE.
- `a`, `b`  in  n  operands; sampled with start, need not be held afterwards.
- `result`  out  2n  registered accumulator/product.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when result is updated.
- `ovf`  out  1  sticky accumulate overflow.

## Operation
- FSM states:
  - IDLE: on start → CALC; otherwise stay.
  - CALC: counter runs 0..n-1; at n-1 → FINISH.
  - FINISH: → IDLE unconditionally.
- On start, capture:
  - magnitudes |a| and |b|; these are the raw bits when signed_mode = 0;
  - the product sign neg = signed_mode & (a[n-1] ^ b[n-1]);
  - the base value: 0 when clr_acc = 1 or acc_en = 0, otherwise the current result.
- Each CALC cycle: add the partial product, i.e. shift/add one multiplier bit, LSB first, into a 2n-bit unsigned product register.
- In FINISH:
  - p = neg ? -prod : prod, as a 2n-bit value;
  - result <= base + p, modulo 2^(2n);
  - done <= 1.
- ovf:
  - Set in FINISH when the add overflows: signed overflow of the 2n-bit sum (signed_mode = 1), or carry out of bit 2n-1 (signed_mode = 0).
  - Cleared in FINISH when the base was 0 by clr_acc/!acc_en and no overflow occurred.
  - Cleared in the cycle after clr_acc is sampled in IDLE.
  - Otherwise holds.
- clr_acc without start in IDLE: next cycle result = 0, ovf = 0, no done.
- clr_acc with start: the operation runs from a zero base. The product alone is the result, even if acc_en = 1.
- start, clr_acc, a, b, and the mode inputs are ignored while busy = 1. There is no queueing.
- The most negative operand (e.g. -128 for n = 8) must be handled exactly. Its magnitude 2^(n-1) fits in n unsigned bits.

## Timing
- Reset, when nReset = 0 at an edge: state IDLE, counter 0, result 0, busy 0, done 0, ovf 0. This applies mid-operation too: the operation is abandoned and no done is issued.
- Latency with start sampled at edge E0:
  - CALC occupies edges E1..En;
  - FINISH updates result, ovf, and done at edge En+1.
  - done is high for exactly the one cycle after En+1.
- busy is high in CALC and FINISH, from after E0 through the cycle ending at En+1. It is low in the cycle in which done is high.
- Back-to-back: start may be asserted in the done cycle. Issue interval is therefore n+2 cycles.
- result is stable at all times other than the FINISH and clear edges.

## Structure
- Package `mult_pkg` holds:
  - the state typedef `mult_state_t` (IDLE, CALC, FINISH);
  - the counter-width function `$clog2(n)`;
  - the shared `mag(x, signed_mode)` magnitude function.
- No sub-module: the FSM and datapath sit in one module, because the shift-add datapath is too small to split.

## Test plan
All values are for n = 8.
- Signed: a = -3 (8'hFD), b = 5, signed_mode = 1, acc_en = 0 → done after 9 edges; result 16'hFFF1; ovf = 0.
- Unsigned extremes: a = b = 8'hFF, signed_mode = 0 → result 16'hFE01. Then signed a = b = -128 → result 16'h4000.
- Accumulate: 100×100 with acc_en = 0, then 100×100 with acc_en = 1 → result 16'h2710, then 16'h4E20.
- Signed overflow:
  - 127×127 three times, the second and third with acc_en = 1 → ovf rises on the third; result 16'hBD03.
  - Then clr_acc alone → result 0 and ovf 0 next cycle.
- Handshake:
  - start pulsed during CALC with different operands → ignored; result and latency unchanged.
  - start in the done cycle → second result after another n+2 cycles.
- Reset mid-op: nReset low at the 4th CALC edge → busy 0, result 0, and no done pulse thereafter.
